// File: rtl/oled_pkg.sv
// Shared constants, command opcodes, FSM states and glyph table for the OLED character renderer.
package oled_pkg;

    localparam int unsigned FONT_W    = 6;
    localparam int unsigned COL_MAX   = 128;
    localparam int unsigned PAGE_MAX  = 8;
    localparam int unsigned ROM_AW    = 10;
    localparam int unsigned ROM_DEPTH = 570;

    localparam logic [7:0] ASCII_FIRST = 8'h20;
    localparam logic [7:0] ASCII_LAST  = 8'h7E;
    localparam logic [7:0] X_LAST      = 8'(COL_MAX - FONT_W);

    localparam logic [7:0] CMD_PAGE   = 8'hB0;
    localparam logic [7:0] CMD_COL_LO = 8'h00;
    localparam logic [7:0] CMD_COL_HI = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD_PG = 3'd1,
        ST_CMD_CL = 3'd2,
        ST_CMD_CH = 3'd3,
        ST_ROM_RD = 3'd4,
        ST_DATA   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Glyph column contents; glyph 0 (space) occupies addresses 0..FONT_W-1 and is blank.
    function automatic logic [7:0] font_byte(input logic [ROM_AW-1:0] addr);
        if (addr < ROM_AW'(FONT_W)) begin
            return 8'h00;
        end
        return {addr[2:0], addr[9:5]} ^ addr[7:0] ^ 8'h5A;
    endfunction

endpackage

// File: rtl/oled_font_rom.sv
// 6x8 font ROM: one byte per glyph column, registered 1-cycle read.
module oled_font_rom
    import oled_pkg::*;
(
    input  logic              clk_50m,
    input  logic [ROM_AW-1:0] addr,
    output logic [7:0]        q
);

    always_ff @(posedge clk_50m) begin
        q <= font_byte(addr);
    end

endmodule

// File: rtl/oled_char_render.sv
// Turns one character draw request into an SSD1306 page-address command triple plus glyph column bytes.
module oled_char_render
    import oled_pkg::*;
(
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       draw_start,
    input  logic [7:0] draw_ascii,
    input  logic [7:0] draw_x,
    input  logic [3:0] draw_y,
    output logic       draw_busy,
    output logic       draw_done,
    output logic       draw_err,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic       wr_dc,
    output logic [7:0] wr_byte
);

    state_t            state, state_nx;
    logic [6:0]        glyph_q;
    logic [6:0]        glyph_in;
    logic [6:0]        x_q;
    logic [2:0]        col_q, col_nx;
    logic [7:0]        cmd_q, cmd_nx;
    logic              valid_nx, dc_nx, busy_nx, done_nx, err_nx, latch;
    logic              xfer, req_ok, ascii_ok;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_q;

    assign xfer     = wr_valid & wr_ready;
    assign req_ok   = (draw_y < 4'(PAGE_MAX)) && (draw_x <= X_LAST);
    assign ascii_ok = (draw_ascii >= ASCII_FIRST) && (draw_ascii <= ASCII_LAST);
    assign glyph_in = ascii_ok ? 7'(draw_ascii - ASCII_FIRST) : 7'd0;

    // glyph*6 as glyph*4 + glyph*2
    assign rom_addr = ROM_AW'({glyph_q, 2'b00}) + ROM_AW'({glyph_q, 1'b0}) + ROM_AW'(col_q);

    // Data bytes come straight from the ROM output register, which holds while col_q is stable.
    assign wr_byte = wr_dc ? rom_q : cmd_q;

    oled_font_rom u_rom (
        .clk_50m (clk_50m),
        .addr    (rom_addr),
        .q       (rom_q)
    );

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            col_q     <= 3'd0;
            cmd_q     <= 8'h00;
            glyph_q   <= 7'd0;
            x_q       <= 7'd0;
            wr_valid  <= 1'b0;
            wr_dc     <= 1'b0;
            draw_busy <= 1'b0;
            draw_done <= 1'b0;
            draw_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            col_q     <= col_nx;
            cmd_q     <= cmd_nx;
            wr_valid  <= valid_nx;
            wr_dc     <= dc_nx;
            draw_busy <= busy_nx;
            draw_done <= done_nx;
            draw_err  <= err_nx;
            if (latch) begin
                glyph_q <= glyph_in;
                x_q     <= draw_x[6:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        col_nx   = col_q;
        cmd_nx   = cmd_q;
        valid_nx = wr_valid;
        dc_nx    = wr_dc;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        latch    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (draw_start) begin
                    if (req_ok) begin
                        state_nx = ST_CMD_PG;
                        latch    = 1'b1;
                        col_nx   = 3'd0;
                        valid_nx = 1'b1;
                        dc_nx    = 1'b0;
                        cmd_nx   = CMD_PAGE | {5'd0, draw_y[2:0]};
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ST_CMD_PG: begin
                if (xfer) begin
                    state_nx = ST_CMD_CL;
                    cmd_nx   = CMD_COL_LO | {4'd0, x_q[3:0]};
                end
            end
            ST_CMD_CL: begin
                if (xfer) begin
                    state_nx = ST_CMD_CH;
                    cmd_nx   = CMD_COL_HI | {5'd0, x_q[6:4]};
                end
            end
            ST_CMD_CH: begin
                if (xfer) begin
                    state_nx = ST_ROM_RD;
                    valid_nx = 1'b0;
                    dc_nx    = 1'b1;
                end
            end
            ST_ROM_RD: begin
                state_nx = ST_DATA;
                valid_nx = 1'b1;
                dc_nx    = 1'b1;
            end
            ST_DATA: begin
                if (xfer) begin
                    valid_nx = 1'b0;
                    if (col_q == 3'(FONT_W - 1)) begin
                        state_nx = ST_DONE;
                        done_nx  = 1'b1;
                        dc_nx    = 1'b0;
                    end else begin
                        state_nx = ST_ROM_RD;
                        col_nx   = 3'(col_q + 3'd1);
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                dc_nx    = 1'b0;
            end
            default: begin
                state_nx = ST_IDLE;
                valid_nx = 1'b0;
                dc_nx    = 1'b0;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_oled_char_render.sv
// Randomised self-checking bench for oled_char_render against a byte-stream reference model.
module tb_oled_char_render;
    import oled_pkg::*;

    logic       clk_50m = 1'b0;
    logic       rst_n = 1'b1;
    logic       draw_start = 1'b0;
    logic [7:0] draw_ascii = 8'h00;
    logic [7:0] draw_x = 8'h00;
    logic [3:0] draw_y = 4'h0;
    logic       wr_ready = 1'b0;
    logic       draw_busy, draw_done, draw_err, wr_valid, wr_dc;
    logic [7:0] wr_byte;

    always #10 clk_50m = ~clk_50m;

    oled_char_render dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .draw_start (draw_start),
        .draw_ascii (draw_ascii),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .draw_busy  (draw_busy),
        .draw_done  (draw_done),
        .draw_err   (draw_err),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_dc      (wr_dc),
        .wr_byte    (wr_byte)
    );

    int checks = 0;
    int errors = 0;

    bit         cap_dc[$];
    logic [7:0] cap_byte[$];
    int         cap_cyc[$];
    bit         exp_dc[$];
    logic [7:0] exp_byte[$];

    int done_cyc, done_cnt, err_cyc, err_cnt;
    int busy_first, busy_last, busy_cnt, valid_cnt, stall_bad, rst_valid;

    logic [7:0] b_ascii, b_x;
    logic [3:0] b_y;

    function automatic bit ref_ok(input logic [7:0] x, input logic [3:0] y);
        return (int'(y) < int'(PAGE_MAX)) && (int'(x) + int'(FONT_W) <= int'(COL_MAX));
    endfunction

    // Expected writer stream for one request, appended to exp_*.
    task automatic ref_push(input logic [7:0] a, input logic [7:0] x, input logic [3:0] y);
        int g;
        if (!ref_ok(x, y)) return;
        g = (int'(a) >= 32 && int'(a) <= 126) ? int'(a) - 32 : 0;
        exp_dc.push_back(1'b0); exp_byte.push_back(8'(8'hB0 + int'(y)));
        exp_dc.push_back(1'b0); exp_byte.push_back(8'(int'(x) % 16));
        exp_dc.push_back(1'b0); exp_byte.push_back(8'(8'h10 + int'(x) / 16));
        for (int i = 0; i < int'(FONT_W); i++) begin
            exp_dc.push_back(1'b1);
            exp_byte.push_back(font_byte(10'(g * int'(FONT_W) + i)));
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 2 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    // Issues a request at cycle 0 and observes ncyc cycles; optional second start at inj_cyc
    // or in the draw_done cycle, optional reset assertion at rst_at.
    task automatic run_draw(input logic [7:0] a, input logic [7:0] x, input logic [3:0] y,
                            input int rmode, input int inj_cyc, input bit injd,
                            input int rst_at, input int ncyc);
        bit pv, pr, pdc;
        logic [7:0] pb;
        cap_dc.delete(); cap_byte.delete(); cap_cyc.delete();
        done_cyc = -1; done_cnt = 0; err_cyc = -1; err_cnt = 0;
        busy_first = -1; busy_last = -1; busy_cnt = 0; valid_cnt = 0;
        stall_bad = 0; rst_valid = 0;
        pv = 1'b0; pr = 1'b0; pdc = 1'b0; pb = 8'h00;
        @(posedge clk_50m); #1;
        draw_start = 1'b1; draw_ascii = a; draw_x = x; draw_y = y;
        wr_ready = ready_for(rmode, 0);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk_50m);
            if (rst_n) begin
                if (pv && !pr && !(wr_valid && wr_byte === pb && wr_dc === pdc)) stall_bad++;
                if (wr_valid && wr_ready) begin
                    cap_dc.push_back(wr_dc); cap_byte.push_back(wr_byte); cap_cyc.push_back(c);
                end
                if (wr_valid) valid_cnt++;
                if (draw_done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
                if (draw_err) begin err_cnt++; if (err_cyc < 0) err_cyc = c; end
                if (draw_busy) begin busy_cnt++; if (busy_first < 0) busy_first = c; busy_last = c; end
            end else if (wr_valid) begin
                rst_valid++;
            end
            pv = wr_valid; pr = wr_ready; pb = wr_byte; pdc = wr_dc;
            if (injd && draw_done) begin
                draw_start = 1'b1; draw_ascii = b_ascii; draw_x = b_x; draw_y = b_y;
            end
            @(posedge clk_50m); #1;
            draw_start = (c + 1 == inj_cyc);
            if (draw_start) begin
                draw_ascii = b_ascii; draw_x = b_x; draw_y = b_y;
            end else begin
                draw_ascii = 8'($urandom); draw_x = 8'($urandom); draw_y = 4'($urandom);
            end
            wr_ready = ready_for(rmode, c + 1);
            if (c + 1 == rst_at) begin
                rst_n = 1'b0;
                #1;
                if (wr_valid) rst_valid++;
            end
        end
        draw_start = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_50m);
        @(negedge clk_50m);
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", wr_valid); end
        checks++; if (wr_dc !== 1'b0) begin errors++; $display("FAIL reset_dc got %b exp 0", wr_dc); end
        checks++; if (wr_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h exp 00", wr_byte); end
        checks++; if (draw_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", draw_busy); end
        checks++; if ({draw_done, draw_err} !== 2'b00) begin errors++; $display("FAIL reset_done_err got %b exp 00", {draw_done, draw_err}); end
        @(posedge clk_50m); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50m);
        checks++; if ({wr_valid, draw_busy} !== 2'b00) begin errors++; $display("FAIL post_reset_idle got %b exp 00", {wr_valid, draw_busy}); end
    endtask

    task automatic test_basic;
        exp_dc.delete(); exp_byte.delete();
        ref_push(8'h41, 8'd10, 4'd2);
        run_draw(8'h41, 8'd10, 4'd2, 0, -1, 1'b0, -1, 30);
        checks++; if (cap_byte.size() != exp_byte.size()) begin errors++; $display("FAIL basic_len got %0d exp %0d", cap_byte.size(), exp_byte.size()); end
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                errors++; $display("FAIL basic_byte%0d got %b/%h exp %b/%h", i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
        if (cap_cyc.size() == 9) begin
            checks++;
            if (cap_cyc[0] != 1 || cap_cyc[2] != 3 || cap_cyc[3] != 5 || cap_cyc[8] != 15) begin
                errors++; $display("FAIL basic_timing got %0d,%0d,%0d,%0d exp 1,3,5,15", cap_cyc[0], cap_cyc[2], cap_cyc[3], cap_cyc[8]);
            end
        end
        checks++; if (done_cyc != 16 || done_cnt != 1) begin errors++; $display("FAIL basic_done got cyc %0d cnt %0d exp 16/1", done_cyc, done_cnt); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL basic_err got %0d exp 0", err_cnt); end
        checks++; if (busy_first != 1 || busy_last != 16 || busy_cnt != 16) begin
            errors++; $display("FAIL basic_busy got %0d..%0d (%0d) exp 1..16 (16)", busy_first, busy_last, busy_cnt);
        end
    endtask

    task automatic test_stall;
        exp_dc.delete(); exp_byte.delete();
        ref_push(8'h41, 8'd10, 4'd2);
        run_draw(8'h41, 8'd10, 4'd2, 1, -1, 1'b0, -1, 50);
        checks++; if (cap_byte.size() != exp_byte.size()) begin errors++; $display("FAIL stall_len got %0d exp %0d", cap_byte.size(), exp_byte.size()); end
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                errors++; $display("FAIL stall_byte%0d got %b/%h exp %b/%h", i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles exp 0", stall_bad); end
        if (cap_cyc.size() > 0) begin
            checks++;
            if (done_cyc != cap_cyc[cap_cyc.size() - 1] + 1 || done_cnt != 1) begin
                errors++; $display("FAIL stall_done got cyc %0d cnt %0d exp %0d/1", done_cyc, done_cnt, cap_cyc[cap_cyc.size() - 1] + 1);
            end
        end
    endtask

    task automatic test_reject;
        logic [7:0] xs[3];
        logic [3:0] ys[3];
        xs[0] = 8'd123; ys[0] = 4'd0;
        xs[1] = 8'd10;  ys[1] = 4'd8;
        xs[2] = 8'd255; ys[2] = 4'd15;
        for (int k = 0; k < 3; k++) begin
            run_draw(8'h41, xs[k], ys[k], 0, -1, 1'b0, -1, 20);
            checks++; if (err_cyc != 1 || err_cnt != 1) begin errors++; $display("FAIL reject%0d_err got cyc %0d cnt %0d exp 1/1", k, err_cyc, err_cnt); end
            checks++; if (valid_cnt != 0 || busy_cnt != 0) begin errors++; $display("FAIL reject%0d_quiet got valid %0d busy %0d exp 0/0", k, valid_cnt, busy_cnt); end
        end
        exp_dc.delete(); exp_byte.delete();
        ref_push(8'h7E, 8'd122, 4'd7);
        run_draw(8'h7E, 8'd122, 4'd7, 0, -1, 1'b0, -1, 30);
        checks++; if (err_cnt != 0 || cap_byte.size() != 9) begin errors++; $display("FAIL edge_accept got err %0d bytes %0d exp 0/9", err_cnt, cap_byte.size()); end
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                errors++; $display("FAIL edge_byte%0d got %b/%h exp %b/%h", i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
    endtask

    task automatic test_blank;
        exp_dc.delete(); exp_byte.delete();
        ref_push(8'h05, 8'd0, 4'd7);
        run_draw(8'h05, 8'd0, 4'd7, 0, -1, 1'b0, -1, 30);
        checks++; if (cap_byte.size() != exp_byte.size()) begin errors++; $display("FAIL blank_len got %0d exp %0d", cap_byte.size(), exp_byte.size()); end
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                errors++; $display("FAIL blank_byte%0d got %b/%h exp %b/%h", i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
    endtask

    task automatic test_ignore;
        b_ascii = 8'h5A; b_x = 8'd40; b_y = 4'd3;
        exp_dc.delete(); exp_byte.delete();
        ref_push(8'h41, 8'd10, 4'd2);
        run_draw(8'h41, 8'd10, 4'd2, 0, 4, 1'b1, -1, 60);
        checks++; if (cap_byte.size() != 9) begin errors++; $display("FAIL ignore_len got %0d exp 9", cap_byte.size()); end
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                errors++; $display("FAIL ignore_byte%0d got %b/%h exp %b/%h", i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
        checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL ignore_flags got done %0d err %0d exp 1/0", done_cnt, err_cnt); end
    endtask

    task automatic test_back_to_back;
        b_ascii = 8'h7A; b_x = 8'd64; b_y = 4'd5;
        exp_dc.delete(); exp_byte.delete();
        ref_push(8'h41, 8'd10, 4'd2);
        ref_push(b_ascii, b_x, b_y);
        run_draw(8'h41, 8'd10, 4'd2, 0, 17, 1'b0, -1, 50);
        checks++; if (cap_byte.size() != 18) begin errors++; $display("FAIL b2b_len got %0d exp 18", cap_byte.size()); end
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                errors++; $display("FAIL b2b_byte%0d got %b/%h exp %b/%h", i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
        if (cap_cyc.size() > 9) begin
            checks++; if (cap_cyc[9] != 18) begin errors++; $display("FAIL b2b_first got cyc %0d exp 18", cap_cyc[9]); end
        end
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done got %0d exp 2", done_cnt); end
    endtask

    task automatic test_reset_mid;
        exp_dc.delete(); exp_byte.delete();
        ref_push(8'h41, 8'd10, 4'd2);
        run_draw(8'h41, 8'd10, 4'd2, 0, -1, 1'b0, 8, 12);
        checks++; if (rst_valid != 0) begin errors++; $display("FAIL rstmid_valid got %0d cycles exp 0", rst_valid); end
        checks++; if (cap_byte.size() != 5) begin errors++; $display("FAIL rstmid_len got %0d exp 5", cap_byte.size()); end
        for (int i = 0; i < 5 && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                errors++; $display("FAIL rstmid_byte%0d got %b/%h exp %b/%h", i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
        @(posedge clk_50m); #1;
        rst_n = 1'b1;
        exp_dc.delete(); exp_byte.delete();
        ref_push(8'h30, 8'h7A, 4'd0);
        run_draw(8'h30, 8'h7A, 4'd0, 0, -1, 1'b0, -1, 30);
        checks++; if (cap_byte.size() != exp_byte.size()) begin errors++; $display("FAIL rstnew_len got %0d exp %0d", cap_byte.size(), exp_byte.size()); end
        for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
            checks++;
            if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                errors++; $display("FAIL rstnew_byte%0d got %b/%h exp %b/%h", i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] a, x;
        logic [3:0] y;
        for (int n = 0; n < 20; n++) begin
            a = 8'($urandom_range(0, 255));
            x = 8'($urandom_range(0, 130));
            y = 4'($urandom_range(0, 9));
            exp_dc.delete(); exp_byte.delete();
            ref_push(a, x, y);
            run_draw(a, x, y, 2, -1, 1'b0, -1, 120);
            if (ref_ok(x, y)) begin
                checks++; if (cap_byte.size() != exp_byte.size()) begin errors++; $display("FAIL rnd%0d_len got %0d exp %0d", n, cap_byte.size(), exp_byte.size()); end
                for (int i = 0; i < exp_byte.size() && i < cap_byte.size(); i++) begin
                    checks++;
                    if ({cap_dc[i], cap_byte[i]} !== {exp_dc[i], exp_byte[i]}) begin
                        errors++; $display("FAIL rnd%0d_byte%0d got %b/%h exp %b/%h", n, i, cap_dc[i], cap_byte[i], exp_dc[i], exp_byte[i]);
                    end
                end
                checks++; if (done_cnt != 1 || err_cnt != 0 || stall_bad != 0) begin
                    errors++; $display("FAIL rnd%0d_flags got done %0d err %0d unstable %0d exp 1/0/0", n, done_cnt, err_cnt, stall_bad);
                end
                checks++; if (busy_first != 1 || busy_last != done_cyc || busy_cnt != done_cyc) begin
                    errors++; $display("FAIL rnd%0d_busy got %0d..%0d (%0d) exp 1..%0d", n, busy_first, busy_last, busy_cnt, done_cyc);
                end
            end else begin
                checks++; if (err_cyc != 1 || err_cnt != 1 || valid_cnt != 0 || busy_cnt != 0) begin
                    errors++; $display("FAIL rnd%0d_reject got err %0d/%0d valid %0d busy %0d exp 1/1/0/0", n, err_cyc, err_cnt, valid_cnt, busy_cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_reject();
        test_blank();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
